// File: rtl/wb_shared_bus_if.sv
// Wishbone shared-bus signal bundle: packed per-master request/response vectors
// and the shared/per-slave fan-out toward peripherals.
interface wb_shared_bus_if #(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_SLAVES  = 4,
    parameter int ADR_WIDTH   = 32,
    parameter int DAT_WIDTH   = 32
);
    logic [NUM_MASTERS*ADR_WIDTH-1:0]     m_adr_i;
    logic [NUM_MASTERS*DAT_WIDTH-1:0]     m_dat_i;
    logic [NUM_MASTERS*DAT_WIDTH/8-1:0]   m_sel_i;
    logic [NUM_MASTERS-1:0]               m_we_i;
    logic [NUM_MASTERS-1:0]               m_cyc_i;
    logic [NUM_MASTERS-1:0]               m_stb_i;
    logic [DAT_WIDTH-1:0]                 m_dat_o;
    logic [NUM_MASTERS-1:0]               m_ack_o;
    logic [NUM_MASTERS-1:0]               m_err_o;
    logic [NUM_MASTERS-1:0]               m_rty_o;

    logic [ADR_WIDTH-1:0]                 s_adr_o;
    logic [DAT_WIDTH-1:0]                 s_dat_o;
    logic [DAT_WIDTH/8-1:0]               s_sel_o;
    logic                                 s_we_o;
    logic [NUM_SLAVES-1:0]                s_cyc_o;
    logic [NUM_SLAVES-1:0]                s_stb_o;
    logic [NUM_SLAVES*DAT_WIDTH-1:0]      s_dat_i;
    logic [NUM_SLAVES-1:0]                s_ack_i;
    logic [NUM_SLAVES-1:0]                s_err_i;
    logic [NUM_SLAVES-1:0]                s_rty_i;

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o
    );

    modport slave (
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i
    );

    modport fabric (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i
    );
endinterface

// File: rtl/wb_shared_bus.sv
// Round-robin Wishbone shared bus with top-bits address decode and bus errors.
// Define WB_XBAR_TIMEOUT_EN to add the unanswered-strobe timeout to ERR.
//
// state | meaning
// IDLE  | no grant; pick next requester after "last"
// BUSY  | grant held; granted master routed to decoded slave
// ERR   | one-cycle m_err_o to granted master; no slave strobe
module wb_shared_bus #(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_SLAVES  = 4,
    parameter int ADR_WIDTH   = 32,
    parameter int DAT_WIDTH   = 32,
    parameter int DEC_WIDTH   = 4,
    parameter logic [NUM_SLAVES*DEC_WIDTH-1:0] SLAVE_BASES = '0,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   reset_n,
    wb_shared_bus_if.fabric        bus,
    output logic [NUM_MASTERS-1:0] gnt_o
);
    localparam int MW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int SEL_W = DAT_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

    state_t                 state_q, state_d;
    logic [MW-1:0]          gidx_q, last_q, win_idx, cand;
    logic                   win_found, granted;
    logic                   g_cyc, g_stb, s_match, r_ack, r_err, r_rty, to_hit;
    logic [ADR_WIDTH-1:0]   g_adr;
    logic [SW-1:0]          sidx;
    logic [NUM_SLAVES-1:0]  hit, s_cyc, s_stb;
    logic [NUM_MASTERS-1:0] m_ack, m_err, m_rty;

    logic [ADR_WIDTH-1:0]   m_adr [NUM_MASTERS];
    logic [DAT_WIDTH-1:0]   m_dat [NUM_MASTERS];
    logic [SEL_W-1:0]       m_sel [NUM_MASTERS];
    logic [DAT_WIDTH-1:0]   s_dat [NUM_SLAVES];

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_out_of_range
        logic timeout_parameter_must_be_1_to_255;
    end

    for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_mst
        assign m_adr[m] = bus.m_adr_i[m*ADR_WIDTH +: ADR_WIDTH];
        assign m_dat[m] = bus.m_dat_i[m*DAT_WIDTH +: DAT_WIDTH];
        assign m_sel[m] = bus.m_sel_i[m*SEL_W +: SEL_W];
    end

    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slv
        assign s_dat[s] = bus.s_dat_i[s*DAT_WIDTH +: DAT_WIDTH];
        assign hit[s]   = (g_adr[ADR_WIDTH-1 -: DEC_WIDTH] == SLAVE_BASES[s*DEC_WIDTH +: DEC_WIDTH]);
    end

    assign granted = |gnt_o;
    assign g_adr   = granted ? m_adr[gidx_q] : '0;
    assign g_cyc   = granted & bus.m_cyc_i[gidx_q];
    assign g_stb   = g_cyc & bus.m_stb_i[gidx_q];

    // Search last+1, last+2, ... so the previous owner goes to the back of the line.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = MW'((int'(last_q) + k) % NUM_MASTERS);
            if (!win_found && bus.m_cyc_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Descending scan so the lowest matching slave index is the one left standing.
    always_comb begin
        s_match = 1'b0;
        sidx    = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                s_match = 1'b1;
                sidx    = SW'(i);
            end
        end
    end

    assign r_ack = s_match & bus.s_ack_i[sidx];
    assign r_err = s_match & bus.s_err_i[sidx];
    assign r_rty = s_match & bus.s_rty_i[sidx];

`ifdef WB_XBAR_TIMEOUT_EN
    logic [7:0] to_cnt;

    assign to_hit = g_stb && s_match && !(r_ack || r_err || r_rty) && (to_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (state_q != BUSY || !g_stb || !s_match || r_ack || r_err || r_rty) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 8'd1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        s_cyc   = '0;
        s_stb   = '0;
        m_ack   = '0;
        m_err   = '0;
        m_rty   = '0;
        unique case (state_q)
            IDLE: begin
                if (win_found) state_d = BUSY;
            end
            BUSY: begin
                if (s_match) begin
                    s_cyc[sidx] = g_cyc;
                    s_stb[sidx] = g_stb;
                end
                if (g_stb) begin
                    m_ack[gidx_q] = r_ack;
                    m_err[gidx_q] = r_err;
                    m_rty[gidx_q] = r_rty;
                end
                if (!g_cyc)                 state_d = IDLE;
                else if (g_stb && !s_match) state_d = ERR;
                else if (to_hit)            state_d = ERR;
            end
            ERR: begin
                if (s_match) s_cyc[sidx] = g_cyc;
                m_err[gidx_q] = 1'b1;
                state_d       = BUSY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_o   <= '0;
            gidx_q  <= '0;
            last_q  <= MW'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && win_found) begin
                gnt_o  <= NUM_MASTERS'(1) << win_idx;
                gidx_q <= win_idx;
            end else if (state_q == BUSY && !g_cyc) begin
                gnt_o  <= '0;
                last_q <= gidx_q;
            end
        end
    end

    assign bus.s_adr_o = g_adr;
    assign bus.s_dat_o = granted ? m_dat[gidx_q] : '0;
    assign bus.s_sel_o = granted ? m_sel[gidx_q] : '0;
    assign bus.s_we_o  = granted & bus.m_we_i[gidx_q];
    assign bus.s_cyc_o = s_cyc;
    assign bus.s_stb_o = s_stb;
    assign bus.m_dat_o = (granted && s_match) ? s_dat[sidx] : '0;
    assign bus.m_ack_o = m_ack;
    assign bus.m_err_o = m_err;
    assign bus.m_rty_o = m_rty;
endmodule
